// File: rtl/strip_pkg.sv
// strip_pkg
// Shared definitions for the strip frame assembler: the default payload
// header value, the field layout of the 19-bit link status word and the
// frame assembler FSM state encoding.
package strip_pkg;

    localparam logic [3:0] STRIP_HDR = 4'b1010;

    // link_message field layout
    localparam int LM_ERR_LSB    = 0;
    localparam int LM_ERR_W      = 5;
    localparam int LM_SYN_LSB    = 5;
    localparam int LM_SYN_W      = 9;
    localparam int LM_LINKED_BIT = 14;
    localparam int LM_STATE_LSB  = 15;
    localparam int LM_STATE_W    = 4;
    localparam int LM_W          = 19;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_COLLECT = 2'd2
    } strip_state_e;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk160 - clock
//   reset  - asynchronous active-high reset
//   inc    - count up by one (ignored at all-ones)
//   clr    - synchronous clear, wins over inc
//   cnt    - counter value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk160,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/strip_frame_assembler.sv
// strip_frame_assembler
// Decodes the link status word into registered fields and assembles
// header-tagged strip words into fixed-length frames, with saturating
// status counters for completed frames, short frames and link breaks.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_HUNT    | unlinked or just (re)linked; waiting for a non-header gap
// ST_ARMED   | gap seen; next header word starts a frame as word 0
// ST_COLLECT | inside a frame (or between back-to-back frames, idx 0)
//
// Ports:
//   clk160          - clock
//   reset           - asynchronous active-high reset
//   strip_data_in   - strip word, header in the top HDR_W bits
//   link_message    - link status {state[18:15], linked[14], sync[13:5], err[4:0]}
//   clear_cnt       - synchronous clear of the three status counters
//   err_cnt, syn_cnt, linked, link_state - registered link status fields
//   frame_data      - last completed frame, first word in the MSBs
//   frame_valid     - one-cycle strobe when frame_data is updated
//   frame_cnt, short_err_cnt, link_break_cnt - saturating status counters
module strip_frame_assembler
    import strip_pkg::*;
#(
    parameter int                WORD_W          = 30,
    parameter int                HDR_W           = 4,
    parameter logic [HDR_W-1:0]  HDR_PATTERN     = STRIP_HDR,
    parameter int                WORDS_PER_FRAME = 4,
    parameter int                CNT_W           = 16,
    localparam int               PAY_W           = WORD_W - HDR_W,
    localparam int               FRAME_W         = WORDS_PER_FRAME * PAY_W
) (
    input  logic                clk160,
    input  logic                reset,
    input  logic [WORD_W-1:0]   strip_data_in,
    input  logic [LM_W-1:0]     link_message,
    input  logic                clear_cnt,
    output logic [4:0]          err_cnt,
    output logic [8:0]          syn_cnt,
    output logic                linked,
    output logic [3:0]          link_state,
    output logic [FRAME_W-1:0]  frame_data,
    output logic                frame_valid,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic [CNT_W-1:0]    short_err_cnt,
    output logic [CNT_W-1:0]    link_break_cnt
);

    localparam int IDX_W = $clog2(WORDS_PER_FRAME);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORDS_PER_FRAME - 1);

    strip_state_e                          state, state_next;
    logic [IDX_W-1:0]                      idx, idx_next;
    logic [WORDS_PER_FRAME-1:0][PAY_W-1:0] words;
    logic [FRAME_W-1:0]                    frame_next;

    logic             hdr_ok;
    logic             lk;
    logic [PAY_W-1:0] payload;
    logic             store;
    logic             frame_done;
    logic             short_abort;
    logic             link_fall;

    assign hdr_ok  = (strip_data_in[WORD_W-1 -: HDR_W] == HDR_PATTERN);
    assign lk      = link_message[LM_LINKED_BIT];
    assign payload = strip_data_in[PAY_W-1:0];

    assign store       = lk && hdr_ok && ((state == ST_ARMED) || (state == ST_COLLECT));
    assign frame_done  = lk && hdr_ok && (state == ST_COLLECT) && (idx == IDX_LAST);
    assign short_abort = lk && !hdr_ok && (state == ST_COLLECT) && (idx != '0);
    assign link_fall   = linked && !lk;

    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (!lk) begin
            state_next = ST_HUNT;
            idx_next   = '0;
        end else begin
            case (state)
                ST_HUNT: begin
                    if (!hdr_ok) state_next = ST_ARMED;
                end
                ST_ARMED: begin
                    if (hdr_ok) begin
                        state_next = ST_COLLECT;
                        idx_next   = IDX_W'(1);
                    end
                end
                ST_COLLECT: begin
                    if (hdr_ok) begin
                        idx_next = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        // gap at idx 0 is a clean inter-frame gap; otherwise
                        // short_abort accounts for the dropped partial frame
                        state_next = ST_ARMED;
                        idx_next   = '0;
                    end
                end
                default: begin
                    state_next = ST_HUNT;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // The last word goes straight from the input into the frame so the
    // frame can be registered on the edge that samples it.
    always_comb begin
        frame_next = '0;
        for (int k = 0; k < WORDS_PER_FRAME; k++) begin
            if (k == WORDS_PER_FRAME - 1) begin
                frame_next[FRAME_W-1-k*PAY_W -: PAY_W] = payload;
            end else begin
                frame_next[FRAME_W-1-k*PAY_W -: PAY_W] = words[k];
            end
        end
    end

    always_ff @(posedge clk160 or posedge reset) begin
        if (reset) begin
            state       <= ST_HUNT;
            idx         <= '0;
            words       <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            err_cnt     <= '0;
            syn_cnt     <= '0;
            linked      <= 1'b0;
            link_state  <= '0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            frame_valid <= frame_done;
            err_cnt     <= link_message[LM_ERR_LSB +: LM_ERR_W];
            syn_cnt     <= link_message[LM_SYN_LSB +: LM_SYN_W];
            linked      <= lk;
            link_state  <= link_message[LM_STATE_LSB +: LM_STATE_W];
            if (store) begin
                words[idx] <= payload;
            end
            if (frame_done) begin
                frame_data <= frame_next;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_frame_cnt (
        .clk160 (clk160),
        .reset  (reset),
        .inc    (frame_done),
        .clr    (clear_cnt),
        .cnt    (frame_cnt)
    );

    sat_counter #(.W(CNT_W)) u_short_err_cnt (
        .clk160 (clk160),
        .reset  (reset),
        .inc    (short_abort),
        .clr    (clear_cnt),
        .cnt    (short_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_link_break_cnt (
        .clk160 (clk160),
        .reset  (reset),
        .inc    (link_fall),
        .clr    (clear_cnt),
        .cnt    (link_break_cnt)
    );

endmodule

// File: tb/tb_strip_frame_assembler.sv
// tb_strip_frame_assembler
// Directed scenarios followed by randomized traffic, all compared against a
// frame-level reference model (payload queue plus "gap seen" flag).
// Counters are built 4 bits wide here so saturation is reachable quickly.
module tb_strip_frame_assembler;

    localparam int WORD_W  = 30;
    localparam int PAY_W   = 26;
    localparam int NWORDS  = 4;
    localparam int FRAME_W = NWORDS * PAY_W;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [3:0] HDR = 4'b1010;

    logic                clk160 = 1'b0;
    logic                reset;
    logic [WORD_W-1:0]   strip_data_in;
    logic [18:0]         link_message;
    logic                clear_cnt;
    logic [4:0]          err_cnt;
    logic [8:0]          syn_cnt;
    logic                linked;
    logic [3:0]          link_state;
    logic [FRAME_W-1:0]  frame_data;
    logic                frame_valid;
    logic [CNT_W-1:0]    frame_cnt;
    logic [CNT_W-1:0]    short_err_cnt;
    logic [CNT_W-1:0]    link_break_cnt;

    strip_frame_assembler #(
        .WORD_W          (WORD_W),
        .HDR_W           (4),
        .HDR_PATTERN     (HDR),
        .WORDS_PER_FRAME (NWORDS),
        .CNT_W           (CNT_W)
    ) dut (
        .clk160          (clk160),
        .reset           (reset),
        .strip_data_in   (strip_data_in),
        .link_message    (link_message),
        .clear_cnt       (clear_cnt),
        .err_cnt         (err_cnt),
        .syn_cnt         (syn_cnt),
        .linked          (linked),
        .link_state      (link_state),
        .frame_data      (frame_data),
        .frame_valid     (frame_valid),
        .frame_cnt       (frame_cnt),
        .short_err_cnt   (short_err_cnt),
        .link_break_cnt  (link_break_cnt)
    );

    always #5 clk160 = ~clk160;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    logic [PAY_W-1:0]   q [NWORDS];
    int                 q_len;
    bit                 m_armed;
    logic [FRAME_W-1:0] m_frame;
    bit                 m_valid;
    int                 m_frames, m_short, m_breaks;
    bit                 m_linked;
    logic [4:0]         m_err;
    logic [8:0]         m_syn;
    logic [3:0]         m_lstate;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic int sat_next(input int v, input bit inc, input bit clr);
        if (clr) return 0;
        if (inc && v < CNT_MAX) return v + 1;
        return v;
    endfunction

    task automatic model_reset();
        q_len = 0; m_armed = 0; m_frame = '0; m_valid = 0;
        m_frames = 0; m_short = 0; m_breaks = 0;
        m_linked = 0; m_err = '0; m_syn = '0; m_lstate = '0;
    endtask

    task automatic check_all();
        check_val("frame_valid", frame_valid, m_valid);
        check_val("frame_data", frame_data, m_frame);
        check_val("frame_cnt", frame_cnt, m_frames);
        check_val("short_err_cnt", short_err_cnt, m_short);
        check_val("link_break_cnt", link_break_cnt, m_breaks);
        check_val("linked", linked, m_linked);
        check_val("err_cnt", err_cnt, m_err);
        check_val("syn_cnt", syn_cnt, m_syn);
        check_val("link_state", link_state, m_lstate);
    endtask

    // One cycle: drive at negedge, model on posedge, compare at next negedge.
    task automatic step(input logic [3:0] h, input logic [PAY_W-1:0] p,
                        input bit l, input bit c);
        logic [18:0] lm;
        bit done, sh, brk;
        lm = 19'($urandom);
        lm[14] = l;
        strip_data_in = {h, p};
        link_message  = lm;
        clear_cnt     = c;
        @(posedge clk160);
        done = 0; sh = 0;
        brk  = m_linked && !l;
        if (!l) begin
            q_len = 0; m_armed = 0;
        end else if (h == HDR) begin
            if (m_armed) begin
                q[q_len] = p;
                q_len++;
                if (q_len == NWORDS) begin
                    done = 1;
                    m_frame = {q[0], q[1], q[2], q[3]};
                    q_len = 0;
                end
            end
        end else begin
            if (q_len != 0) sh = 1;
            q_len = 0;
            m_armed = 1;
        end
        m_valid  = done;
        m_frames = sat_next(m_frames, done, c);
        m_short  = sat_next(m_short, sh, c);
        m_breaks = sat_next(m_breaks, brk, c);
        m_linked = l;
        m_err    = lm[4:0];
        m_syn    = lm[13:5];
        m_lstate = lm[18:15];
        @(negedge clk160);
        check_all();
    endtask

    task automatic hword(input logic [PAY_W-1:0] p);
        step(HDR, p, 1'b1, 1'b0);
    endtask

    task automatic gap();
        step(4'h0, '0, 1'b1, 1'b0);
    endtask

    // Reset held for 3 cycles; optionally a live header stream keeps running.
    task automatic do_reset(input bit stream);
        @(negedge clk160);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            strip_data_in = stream ? {HDR, 26'(i + 100)} : '0;
            link_message  = 19'h04000;
            clear_cnt     = 1'b0;
            @(negedge clk160);
        end
        check_all();
        reset = 1'b0;
    endtask

    logic [FRAME_W-1:0] saved;

    initial begin
        reset = 1'b1;
        strip_data_in = '0;
        link_message = '0;
        clear_cnt = 1'b0;
        model_reset();

        // basic frame
        do_reset(0);
        gap();
        hword(26'h1); hword(26'h2); hword(26'h3); hword(26'h4);
        check_val("t1_valid_after_last", frame_valid, 1'b1);
        gap();
        check_val("t1_valid_single", frame_valid, 1'b0);
        check_val("t1_frame", frame_data, {26'h1, 26'h2, 26'h3, 26'h4});
        check_val("t1_frame_cnt", frame_cnt, 1);

        // back-to-back frames
        do_reset(0);
        gap();
        for (int i = 0; i < 8; i++) hword(26'(32'h100 + i));
        check_val("t2_frame_cnt", frame_cnt, 2);
        check_val("t2_short", short_err_cnt, 0);
        check_val("t2_frame", frame_data, {26'h104, 26'h105, 26'h106, 26'h107});

        // short frame, then a good one
        saved = frame_data;
        gap(); hword(26'h3AA); hword(26'h3BB); gap();
        check_val("t3_short", short_err_cnt, 1);
        check_val("t3_frame_held", frame_data, saved);
        for (int i = 0; i < 4; i++) hword(26'(32'h200 + i));
        check_val("t3_frame_cnt", frame_cnt, 3);

        // stream active across reset release
        do_reset(1);
        for (int i = 0; i < 6; i++) hword(26'(32'h300 + i));
        check_val("t4_no_frame", frame_cnt, 0);
        gap();
        for (int i = 0; i < 4; i++) hword(26'(32'h400 + i));
        check_val("t4_first_word", frame_data[FRAME_W-1 -: PAY_W], 26'h400);
        check_val("t4_frame_cnt", frame_cnt, 1);

        // link drop mid-frame
        do_reset(0);
        gap(); hword(26'h11);
        step(HDR, 26'h12, 1'b0, 1'b0);
        check_val("t5_linked_low", linked, 1'b0);
        for (int i = 0; i < 5; i++) hword(26'(32'h500 + i));
        check_val("t5_breaks", link_break_cnt, 1);
        check_val("t5_short", short_err_cnt, 0);
        check_val("t5_no_frame", frame_cnt, 0);
        gap();
        for (int i = 0; i < 4; i++) hword(26'(32'h600 + i));
        check_val("t5_frame_cnt", frame_cnt, 1);

        // saturation and clear versus increment
        do_reset(0);
        gap();
        for (int i = 0; i < (CNT_MAX + 2) * NWORDS; i++) hword(26'($urandom));
        check_val("t6_sat", frame_cnt, CNT_MAX);
        hword(26'h7); hword(26'h8); hword(26'h9);
        step(HDR, 26'hA, 1'b1, 1'b1);
        check_val("t6_clear_wins", frame_cnt, 0);
        check_val("t6_valid", frame_valid, 1'b1);

        // randomized traffic
        do_reset(0);
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] h;
            int r;
            r = $urandom_range(0, 9);
            if (r < 7) h = HDR;
            else if (r < 9) h = 4'h0;
            else h = 4'($urandom);
            step(h, 26'($urandom), ($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 99) == 0));
            if (i == 1500) do_reset($urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/strip_frame_assembler.md
Name: strip_frame_assembler

Overview:
- Parametrised successor to the strip TDS data checker. Runs on clk160 and sits after the strip deserializer/link-lock logic.
- Decodes the link status word into registered fields and assembles header-tagged strip words into fixed-length frames. Emits each frame with a one-cycle valid strobe.
- Adds behaviour the previous checker lacked: back-to-back frame handling, short-frame error detection, unlinked abort, and saturating status counters with synchronous clear.

Parameters:
- WORD_W, 30, strip input word width including header.
- HDR_W, 4, header field width, located at bits [WORD_W-1 -: HDR_W].
- HDR_PATTERN, 4'b1010, header value marking a payload word.
- WORDS_PER_FRAME, 4, payload words per frame; must be >= 2.
- CNT_W, 16, width of the status counters.
- Derived (localparam): PAY_W = WORD_W-HDR_W (26); FRAME_W = WORDS_PER_FRAME*PAY_W (104).

Ports:
- clk160  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- strip_data_in  in  WORD_W  strip word, one per cycle.
- link_message  in  19  link status: [4:0] err, [13:5] sync count, [14] linked, [18:15] link FSM state.
- clear_cnt  in  1  synchronous clear of all status counters.
- err_cnt  out  5  registered link_message[4:0].
- syn_cnt  out  9  registered link_message[13:5].
- linked  out  1  registered link_message[14].
- link_state  out  4  registered link_message[18:15].
- frame_data  out  FRAME_W  last completed frame; first word in the MSBs.
- frame_valid  out  1  one-cycle strobe; frame_data is valid on this cycle.
- frame_cnt  out  CNT_W  completed frames, saturating.
- short_err_cnt  out  CNT_W  aborted short frames, saturating.
- link_break_cnt  out  CNT_W  linked 1->0 transitions, saturating.

Behaviour:
- Reset: all outputs 0, FSM in HUNT, word index 0, shift register 0.
- Status decode: err_cnt, syn_cnt, linked and link_state are plain registers with 1-cycle latency.
- Definitions:
  - hdr_ok = (strip_data_in[WORD_W-1 -: HDR_W] == HDR_PATTERN).
  - lk = link_message[14], sampled in the same cycle as the data word.
  - payload = strip_data_in[PAY_W-1:0].
- FSM states: HUNT, ARMED, COLLECT. Priority: !lk overrides everything.
  - Any state, !lk: go to HUNT, index 0. No error; any partial frame is discarded.
  - HUNT: non-header word while lk -> ARMED. Header words are ignored, so a stream already running at reset release or relink is never joined mid-frame.
  - ARMED, hdr_ok: store payload as word 0, index 1 -> COLLECT. Otherwise stay in ARMED.
  - COLLECT, hdr_ok: store payload at the current index.
    - If index == WORDS_PER_FRAME-1: register the full frame into frame_data, pulse frame_valid next cycle, index 0, stay in COLLECT (back-to-back frames allowed).
    - Otherwise increment the index.
  - COLLECT, !hdr_ok, index 0: -> ARMED. This is a clean inter-frame gap; no error.
  - COLLECT, !hdr_ok, index != 0: short frame. Increment short_err_cnt, drop the partial data, -> ARMED.
- Frame layout: word k (0 = first received) occupies frame_data[FRAME_W-1-k*PAY_W -: PAY_W].
- Latency: frame_valid is high exactly 1 cycle after the clk160 edge that samples the last word.
- frame_data is held until the next completed frame. It is never updated by aborted frames.
- frame_valid is a single-cycle pulse. Back-to-back frames give a pulse every WORDS_PER_FRAME cycles.
- link_break_cnt increments when the registered linked is 1 and lk is 0, i.e. the output falls on the next edge.
- Counters:
  - Each saturates at 2^CNT_W-1.
  - frame_cnt increments in the same cycle frame_valid is asserted.
  - clear_cnt forces all three to 0. Clear wins over a simultaneous increment.
- Reset asserted mid-frame: immediate return to the reset state. After release, the FSM needs a non-header gap before accepting a frame.

Decomposition:
- Shared package strip_pkg holds:
  - header constant STRIP_HDR = 4'b1010;
  - link_message field offsets;
  - FSM state encoding (2-bit enum).
- One sub-module, sat_counter: parameter W, inputs inc and clr (clr priority), output cnt. Instantiated three times.

Test Plan:
- Reset, lk=1, one gap word 0x0, then 4 header words with payloads 0x1,0x2,0x3,0x4, then a gap -> one frame_valid pulse 1 cycle after the 4th word; frame_data = {26'h1,26'h2,26'h3,26'h4}; frame_cnt=1.
- 8 consecutive header words after a gap -> frame_valid pulses 4 cycles apart; frame_cnt=2; short_err_cnt=0.
- Gap, then 2 header words, then a gap -> no frame_valid; short_err_cnt=1; frame_data unchanged. The next 4-word frame is then accepted normally.
- Header stream already active when reset deasserts -> no frame until a gap occurs; the first frame's word 0 is the first header after the gap.
- lk drops during word 2, then returns -> no error, link_break_cnt=1, linked output falls 1 cycle later; a new frame needs a gap after relink.
- Preload frame_cnt to 0xFFFF via forced frames, then complete another frame -> stays at 0xFFFF. Assert clear_cnt in the same cycle as a frame completion -> frame_cnt=0.
